branch_pht: RTL and testbench
=============================

Name: branch_pht

Overview:
- Parametrised pattern history table of saturating counters for dynamic branch prediction.
- Generalises the single 2-bit saturating-counter predictor to 2^IDX_W entries of CNT_W bits, indexed by fetch PC.
- Adds a registered prediction port and a separate resolve/update port from execute.
- Sits between the IF stage (prediction request) and the EX stage (branch resolution).

Parameters:
- CNT_W, 2: counter width in bits; legal range 1..4.
- IDX_W, 6: index width; table depth = 2^IDX_W entries.
- PC_W, 32: PC width.
- PC_LSB, 2: lowest PC bit used for indexing (word-aligned instructions).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- pred_valid  in  1  prediction request this cycle
- pred_pc  in  PC_W  PC of the fetched instruction
- pred_rsp_valid  out  1  prediction response valid
- pred_taken  out  1  predicted direction (counter MSB)
- pred_idx  out  IDX_W  table index used; carried down the pipe and returned on upd_idx
- upd_valid  in  1  resolved branch this cycle
- upd_idx  in  IDX_W  index to update
- upd_taken  in  1  actual direction

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-low (rstn), applied without waiting for clk.
  - Every counter is set to weakly-not-taken: 2^(CNT_W-1)-1 (01 for CNT_W=2).
  - pred_rsp_valid=0, pred_taken=0, pred_idx=0.
  - Reset asserted mid-operation discards any in-flight response and restores all counters.
- Index: idx = pred_pc[PC_LSB +: IDX_W]. PC bits outside this field are ignored.
- Prediction latency is 1 cycle:
  - pred_valid at edge N gives pred_rsp_valid=1 in cycle N+1.
  - pred_taken = MSB of counter[idx]; pred_idx = idx.
  - Responses arrive back to back with no bubbles. With no request, pred_rsp_valid=0 and pred_taken/pred_idx hold their last values.
- Update takes effect at the clock edge where upd_valid=1:
  - upd_taken=1: counter increments, saturating at 2^CNT_W-1.
  - upd_taken=0: counter decrements, saturating at 0.
  - No wrap-around in either direction.
- upd_valid=0: no counter changes. Counters are modified only through the update port.
- Same-cycle read and write to the same index: write-first bypass. The prediction registered that cycle uses the post-update counter value.
- Same-cycle read and write to different indices are independent.
- CNT_W=1 degenerates to a last-outcome predictor: the counter equals the last outcome.
- No X propagation: the storage array is fully reset. Storage is flops, not inferred RAM.

Optional Feature:
- Macro: BRANCH_PHT_GSHARE_EN
- Defined:
  - Adds a global history register ghr[IDX_W-1:0], reset to 0.
  - idx = pred_pc[PC_LSB +: IDX_W] XOR ghr.
  - On each upd_valid edge: ghr <= {ghr[IDX_W-2:0], upd_taken}. History is updated non-speculatively at resolve.
  - Same-cycle predict and update: the prediction index uses the pre-shift ghr.
  - pred_idx returns the hashed index, so the update port is unchanged.
- Undefined: no ghr flops; index is the PC bits only; port list is identical.

Decomposition:
- Shared package branch_pred_pkg:
  - localparam counter init value function/constant
  - counter max constant
  - typedef for counter (logic [CNT_W-1:0])
  - typedef for index
- One sub-module: sat_counter_step. It is combinational: in cnt, dir, en; out next cnt with saturation. It is instantiated once on the update path and reused by future predictors (BTB hysteresis, tournament chooser).

Test Plan:
- Reset check: deassert rstn, then predict pc=0x0000_0000 → pred_rsp_valid=1 next cycle, pred_taken=0, pred_idx=0. Probe all 64 indices → all read 01.
- Saturate up: 3 updates taken at idx 5 (pc=0x14) → counter 01→10→11→11. Predict pc=0x14 → taken=1. A 4th taken update leaves the counter at 11.
- Saturate down / hysteresis: from 11, one not-taken → 10, still predicts taken. A second → 01, predicts not-taken. Two more → 00, no wrap to 11.
- Bypass: counter at idx 3 = 01; same cycle pred_pc=0x0C and upd_idx=3, upd_taken=1 → response taken=1 (value 10). Same cycle with a different update idx → response taken=0.
- Async reset mid-run: train idx 7 to 11, assert rstn between clock edges → outputs clear immediately. After release, predict idx 7 → taken=0.
- GSHARE (macro defined): updates taken, taken, not-taken → ghr=6'b000110. Predict pc=0x28 (pc idx 10) → pred_idx=10^6=12. Macro undefined → pred_idx=10.

Source files
------------

// File: rtl/branch_pred_pkg.sv
// rtl/branch_pred_pkg.sv - shared constants, helpers and types for branch predictor tables
package branch_pred_pkg;

  // Widest counter any predictor table in this family may use.
  localparam int CNT_W_MAX = 4;

  // Default geometry of the pattern history table.
  localparam int CNT_W_DEF = 2;
  localparam int IDX_W_DEF = 6;

  typedef logic [CNT_W_DEF-1:0] cnt_t;
  typedef logic [IDX_W_DEF-1:0] idx_t;

  // Weakly-not-taken: one below the taken threshold, 2^(w-1)-1.
  function automatic logic [CNT_W_MAX-1:0] cnt_init(input int cnt_w);
    return CNT_W_MAX'((1 << (cnt_w - 1)) - 1);
  endfunction

  // Saturation ceiling of a w-bit counter, 2^w-1.
  function automatic logic [CNT_W_MAX-1:0] cnt_max(input int cnt_w);
    return CNT_W_MAX'((1 << cnt_w) - 1);
  endfunction

endpackage

// File: rtl/sat_counter_step.sv
// rtl/sat_counter_step.sv - combinational next-value of a saturating up/down counter
module sat_counter_step
  import branch_pred_pkg::*;
#(
  parameter int W = 2
) (
  input  logic [W-1:0] cnt_i,
  input  logic         dir_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] MAX_VAL = W'(cnt_max(W));

  // Step toward the resolved direction, holding at either rail.
  always_comb begin
    cnt_o = cnt_i;
    if (en_i) begin
      if (dir_i) begin
        if (cnt_i != MAX_VAL) cnt_o = cnt_i + 1'b1;
      end else begin
        if (cnt_i != '0) cnt_o = cnt_i - 1'b1;
      end
    end
  end

endmodule

// File: rtl/branch_pht.sv
// rtl/branch_pht.sv - pattern history table predictor; BRANCH_PHT_GSHARE_EN adds gshare hashing
module branch_pht
  import branch_pred_pkg::*;
#(
  parameter int CNT_W  = 2,
  parameter int IDX_W  = 6,
  parameter int PC_W   = 32,
  parameter int PC_LSB = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             pred_valid,
  input  logic [PC_W-1:0]  pred_pc,
  output logic             pred_rsp_valid,
  output logic             pred_taken,
  output logic [IDX_W-1:0] pred_idx,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(cnt_init(CNT_W));

  logic [CNT_W-1:0] cnt_q [DEPTH];
  logic [CNT_W-1:0] cnt_d [DEPTH];

  logic [IDX_W-1:0] pc_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [CNT_W-1:0] upd_cur;
  logic [CNT_W-1:0] upd_next;
  logic [CNT_W-1:0] rd_cnt;

  logic             rsp_valid_q, rsp_valid_d;
  logic             taken_q, taken_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  // Only the index field of the PC matters; the rest is deliberately dropped.
  logic unused_pc;
  assign unused_pc = ^pred_pc;

  assign pc_idx = pred_pc[PC_LSB +: IDX_W];

`ifdef BRANCH_PHT_GSHARE_EN
  logic [IDX_W-1:0] ghr_q, ghr_d;

  // Hash with the history as it stood before any same-cycle resolve.
  assign rd_idx = pc_idx ^ ghr_q;

  // History shifts only on resolved branches, so it is never speculative.
  always_comb begin
    ghr_d = ghr_q;
    if (upd_valid) ghr_d = {ghr_q[IDX_W-2:0], upd_taken};
  end

  // Global history register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ghr_q <= '0;
    else       ghr_q <= ghr_d;
  end
`else
  assign rd_idx = pc_idx;
`endif

  assign upd_cur = cnt_q[upd_idx];

  sat_counter_step #(
    .W(CNT_W)
  ) u_step (
    .cnt_i (upd_cur),
    .dir_i (upd_taken),
    .en_i  (upd_valid),
    .cnt_o (upd_next)
  );

  // Write-first: a same-index resolve is visible to this cycle's lookup.
  assign rd_cnt = (upd_valid && (upd_idx == rd_idx)) ? upd_next : cnt_q[rd_idx];

  // Only the resolve port may modify the table.
  always_comb begin
    cnt_d = cnt_q;
    if (upd_valid) cnt_d[upd_idx] = upd_next;
  end

  // Counter storage, fully reset so no X ever reaches a prediction.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) cnt_q[i] <= CNT_INIT;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Response payload holds its last value when no request arrives.
  always_comb begin
    rsp_valid_d = pred_valid;
    taken_d     = taken_q;
    idx_d       = idx_q;
    if (pred_valid) begin
      taken_d = rd_cnt[CNT_W-1];
      idx_d   = rd_idx;
    end
  end

  // Registered prediction response.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_valid_q <= 1'b0;
      taken_q     <= 1'b0;
      idx_q       <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      taken_q     <= taken_d;
      idx_q       <= idx_d;
    end
  end

  assign pred_rsp_valid = rsp_valid_q;
  assign pred_taken     = taken_q;
  assign pred_idx       = idx_q;

endmodule

// File: tb/tb_branch_pht.sv
// tb/tb_branch_pht.sv - directed self-checking bench for branch_pht
module tb_branch_pht;

  logic       clk;
  logic       rstn;
  logic       pred_valid;
  logic [31:0] pred_pc;
  logic       pred_rsp_valid;
  logic       pred_taken;
  logic [5:0] pred_idx;
  logic       upd_valid;
  logic [5:0] upd_idx;
  logic       upd_taken;

  int n_cmp;
  int n_bad;
  logic [5:0] ghr_m;

  branch_pht dut (
    .clk            (clk),
    .rstn           (rstn),
    .pred_valid     (pred_valid),
    .pred_pc        (pred_pc),
    .pred_rsp_valid (pred_rsp_valid),
    .pred_taken     (pred_taken),
    .pred_idx       (pred_idx),
    .upd_valid      (upd_valid),
    .upd_idx        (upd_idx),
    .upd_taken      (upd_taken)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // PC whose hashed index lands on the wanted table entry.
  function automatic logic [31:0] pc_for(input logic [5:0] idx);
    logic [5:0] h;
    h = idx ^ ghr_m;
    return {24'h0, h, 2'b00};
  endfunction

  task automatic ghr_shift(input logic t);
`ifdef BRANCH_PHT_GSHARE_EN
    ghr_m = {ghr_m[4:0], t};
`else
    ghr_m = ghr_m;
`endif
  endtask

  task automatic do_update(input logic [5:0] idx, input logic t);
    upd_valid = 1'b1;
    upd_idx   = idx;
    upd_taken = t;
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    ghr_shift(t);
  endtask

  task automatic do_predict(input logic [5:0] idx);
    pred_valid = 1'b1;
    pred_pc    = pc_for(idx);
    @(posedge clk);
    #1;
    pred_valid = 1'b0;
  endtask

  task automatic chk_pred(input string name, input logic exp_taken, input logic [5:0] exp_idx);
    n_cmp++;
    if (pred_rsp_valid !== 1'b1 || pred_taken !== exp_taken || pred_idx !== exp_idx) begin
      n_bad++;
      $display("FAIL %s: got valid=%b taken=%b idx=%0d, want valid=1 taken=%b idx=%0d",
               name, pred_rsp_valid, pred_taken, pred_idx, exp_taken, exp_idx);
    end
  endtask

  task automatic test_reset;
    n_cmp++;
    if (pred_rsp_valid !== 1'b0 || pred_taken !== 1'b0 || pred_idx !== 6'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got valid=%b taken=%b idx=%0d, want 0/0/0",
               pred_rsp_valid, pred_taken, pred_idx);
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    do_predict(6'd0);
    chk_pred("reset_first_predict", 1'b0, 6'd0);
    // Idle cycle: valid drops, payload holds.
    @(posedge clk);
    #1;
    n_cmp++;
    if (pred_rsp_valid !== 1'b0 || pred_idx !== 6'd0 || pred_taken !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_hold: got valid=%b taken=%b idx=%0d, want valid=0 taken=0 idx=0",
               pred_rsp_valid, pred_taken, pred_idx);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 64; i++) begin
      pred_valid = 1'b1;
      pred_pc    = pc_for(6'(i));
      @(posedge clk);
      #1;
      chk_pred("probe_all", 1'b0, 6'(i));
    end
    pred_valid = 1'b0;
    // Stale response payload after the burst: last index held.
    @(posedge clk);
    #1;
    n_cmp++;
    if (pred_rsp_valid !== 1'b0 || pred_idx !== 6'd63) begin
      n_bad++;
      $display("FAIL burst_end_hold: got valid=%b idx=%0d, want valid=0 idx=63",
               pred_rsp_valid, pred_idx);
    end
  endtask

  task automatic test_saturate;
    // 01 -> 10 -> 11 -> 11
    do_update(6'd5, 1'b1);
    do_update(6'd5, 1'b1);
    do_update(6'd5, 1'b1);
    do_predict(6'd5);
    chk_pred("sat_up_taken", 1'b1, 6'd5);
    do_update(6'd5, 1'b1);
    // 11 -> 10: still taken (proves the 4th did not wrap)
    do_update(6'd5, 1'b0);
    do_predict(6'd5);
    chk_pred("hyst_10", 1'b1, 6'd5);
    // 10 -> 01
    do_update(6'd5, 1'b0);
    do_predict(6'd5);
    chk_pred("hyst_01", 1'b0, 6'd5);
    // 01 -> 00 -> 00, no wrap to 11
    do_update(6'd5, 1'b0);
    do_update(6'd5, 1'b0);
    do_predict(6'd5);
    chk_pred("sat_down_nowrap", 1'b0, 6'd5);
    // From 00 one taken gives 01, still not-taken
    do_update(6'd5, 1'b1);
    do_predict(6'd5);
    chk_pred("sat_down_floor", 1'b0, 6'd5);
  endtask

  task automatic test_bypass;
    // Same index: idx 3 at 01, taken update -> response sees 10.
    pred_valid = 1'b1;
    pred_pc    = pc_for(6'd3);
    upd_valid  = 1'b1;
    upd_idx    = 6'd3;
    upd_taken  = 1'b1;
    @(posedge clk);
    #1;
    pred_valid = 1'b0;
    upd_valid  = 1'b0;
    ghr_shift(1'b1);
    chk_pred("bypass_same_inc", 1'b1, 6'd3);
    // Same index, decrement: 10 -> 01 seen immediately.
    pred_valid = 1'b1;
    pred_pc    = pc_for(6'd3);
    upd_valid  = 1'b1;
    upd_idx    = 6'd3;
    upd_taken  = 1'b0;
    @(posedge clk);
    #1;
    pred_valid = 1'b0;
    upd_valid  = 1'b0;
    ghr_shift(1'b0);
    chk_pred("bypass_same_dec", 1'b0, 6'd3);
    // Different index: idx 9 at 01 unaffected by update to idx 10.
    pred_valid = 1'b1;
    pred_pc    = pc_for(6'd9);
    upd_valid  = 1'b1;
    upd_idx    = 6'd10;
    upd_taken  = 1'b1;
    @(posedge clk);
    #1;
    pred_valid = 1'b0;
    upd_valid  = 1'b0;
    ghr_shift(1'b1);
    chk_pred("bypass_diff_idx", 1'b0, 6'd9);
    // Idx 10 got that update: 01 -> 10.
    do_predict(6'd10);
    chk_pred("diff_idx_written", 1'b1, 6'd10);
  endtask

  task automatic test_no_update;
    upd_idx   = 6'd11;
    upd_taken = 1'b1;
    upd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    do_predict(6'd11);
    chk_pred("upd_valid_low", 1'b0, 6'd11);
  endtask

  task automatic test_async_reset;
    do_update(6'd7, 1'b1);
    do_update(6'd7, 1'b1);
    do_predict(6'd7);
    chk_pred("train_idx7", 1'b1, 6'd7);
    #2;
    rstn = 1'b0;
    #1;
    n_cmp++;
    if (pred_rsp_valid !== 1'b0 || pred_taken !== 1'b0 || pred_idx !== 6'd0) begin
      n_bad++;
      $display("FAIL async_reset_clear: got valid=%b taken=%b idx=%0d, want 0/0/0",
               pred_rsp_valid, pred_taken, pred_idx);
    end
    #3;
    rstn  = 1'b1;
    ghr_m = 6'd0;
    @(posedge clk);
    #1;
    do_predict(6'd7);
    chk_pred("after_reset_idx7", 1'b0, 6'd7);
    do_predict(6'd10);
    chk_pred("after_reset_idx10", 1'b0, 6'd10);
  endtask

  task automatic test_gshare;
    do_update(6'd20, 1'b1);
    do_update(6'd20, 1'b1);
    do_update(6'd20, 1'b0);
    pred_valid = 1'b1;
    pred_pc    = 32'h0000_0028;
    @(posedge clk);
    #1;
    pred_valid = 1'b0;
`ifdef BRANCH_PHT_GSHARE_EN
    chk_pred("gshare_idx", 1'b0, 6'd12);
`else
    chk_pred("pc_only_idx", 1'b0, 6'd10);
`endif
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    ghr_m      = 6'd0;
    rstn       = 1'b0;
    pred_valid = 1'b0;
    pred_pc    = 32'h0;
    upd_valid  = 1'b0;
    upd_idx    = 6'd0;
    upd_taken  = 1'b0;
    #12;
    test_reset;
    test_back_to_back;
    test_saturate;
    test_bypass;
    test_no_update;
    test_async_reset;
    test_gshare;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
